// File: rtl/ts_delay_pkg.sv
// ts_delay_pkg: shared types and defaults for the timed-delay server.
//   state_t        : server FSM states (IDLE, RUN, FIN)
//   UNIT_RATIO_DEF : precision ticks per time unit (1 s / 1 us)
//   DELAY_W_DEF    : default width of a requested delay, in units
//   prec_width()   : width of the precision counter for a given ratio (min 1)
package ts_delay_pkg;

    localparam int UNIT_RATIO_DEF = 1000000;
    localparam int DELAY_W_DEF    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // $clog2 gives 0 for a ratio of 1; a zero-width counter is not legal,
    // so one bit is kept and simply never leaves 0.
    function automatic int prec_width(input int ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/ts_delay_server_if.sv
// ts_delay_server_if: request/status bundle between a delay initiator
// (master) and ts_delay_server (slave).
//   tick_en       : precision tick strobe (master -> slave)
//   req_valid     : request present (master -> slave)
//   req_delay     : requested delay in units (master -> slave)
//   abort         : cancel the active request (master -> slave)
//   req_ready     : server idle and able to accept (slave -> master)
//   busy          : request in progress (slave -> master)
//   done          : one-cycle completion pulse (slave -> master)
//   aborted       : one-cycle cancellation pulse (slave -> master)
//   units_elapsed : whole units elapsed (slave -> master)
//   prec_count    : precision ticks within the current unit (slave -> master)
//   dbg_state     : server FSM state, for observation only
//
// Handshake: a request transfers on a rising clock edge where req_valid
// and req_ready are both 1; req_delay is sampled on that edge. req_ready is
// a function of registered state only, so it never depends on req_valid.
interface ts_delay_server_if
    import ts_delay_pkg::*;
#(
    parameter int UNIT_RATIO = UNIT_RATIO_DEF,
    parameter int DELAY_W    = DELAY_W_DEF
);
    localparam int PREC_W = prec_width(UNIT_RATIO);

    logic               tick_en;
    logic               req_valid;
    logic [DELAY_W-1:0] req_delay;
    logic               abort;
    logic               req_ready;
    logic               busy;
    logic               done;
    logic               aborted;
    logic [DELAY_W-1:0] units_elapsed;
    logic [PREC_W-1:0]  prec_count;
    state_t             dbg_state;

    modport master (
        output tick_en, req_valid, req_delay, abort,
        input  req_ready, busy, done, aborted, units_elapsed, prec_count, dbg_state
    );

    modport slave (
        input  tick_en, req_valid, req_delay, abort,
        output req_ready, busy, done, aborted, units_elapsed, prec_count, dbg_state
    );

endinterface

// File: rtl/ts_prec_counter.sv
// ts_prec_counter: modulo-RATIO precision counter.
//   clock, reset_n : clock and synchronous active-low reset
//   clr_i          : force the count to 0 (has priority over en_i)
//   en_i           : advance one precision step
//   count_o        : current count, 0 .. RATIO-1
//   at_max_o       : count is RATIO-1 (next enabled step wraps)
//   wrap_o         : enabled step that wraps to 0, i.e. one whole unit done
module ts_prec_counter
    import ts_delay_pkg::*;
#(
    parameter int RATIO = 4,
    localparam int W    = prec_width(RATIO)
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         at_max_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] LAST = W'(RATIO - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign at_max_o = (count_q == LAST);
    assign wrap_o   = en_i && at_max_o;
    assign count_o  = count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = at_max_o ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ts_delay_server.sv
// ts_delay_server: accepts one delay request (in time units) and counts
// precision ticks until it expires, then pulses done for one cycle.
//   clock, reset_n : clock and synchronous active-low reset
//   bus            : ts_delay_server_if slave port (request, abort, tick
//                    strobe in; ready/busy/done/aborted and counters out)
// All status outputs come straight from registers: no input-to-output
// combinational path.
module ts_delay_server
    import ts_delay_pkg::*;
#(
    parameter int UNIT_RATIO = UNIT_RATIO_DEF,
    parameter int DELAY_W    = DELAY_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    ts_delay_server_if.slave bus
);

    localparam int PREC_W = prec_width(UNIT_RATIO);

    state_t             state_q, state_d;
    logic [DELAY_W-1:0] target_q, target_d;
    logic [DELAY_W-1:0] units_q, units_d;
    logic               aborted_q, aborted_d;

    logic [PREC_W-1:0]  prec_cnt;
    logic               at_max;
    logic               wrap;
    logic               cnt_en;
    logic               cnt_clr;
    logic               last_unit;
    logic               expiring;

    // The next unit wrap completes the request. Compared one bit wider so
    // the +1 can never alias.
    assign last_unit = (({1'b0, units_q} + {{DELAY_W{1'b0}}, 1'b1}) == {1'b0, target_q});
    assign expiring  = bus.tick_en && at_max && last_unit;

    // An abort freezes the counters, except when it coincides with the
    // expiring tick: completion takes priority in that case.
    assign cnt_en  = (state_q == RUN) && bus.tick_en && (!bus.abort || expiring);
    assign cnt_clr = (state_q == IDLE) && bus.req_valid;

    ts_prec_counter #(
        .RATIO (UNIT_RATIO)
    ) u_prec (
        .clock    (clock),
        .reset_n  (reset_n),
        .clr_i    (cnt_clr),
        .en_i     (cnt_en),
        .count_o  (prec_cnt),
        .at_max_o (at_max),
        .wrap_o   (wrap)
    );

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        units_d   = units_q;
        aborted_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    target_d = bus.req_delay;
                    units_d  = '0;
                    state_d  = (bus.req_delay == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (wrap) begin
                    units_d = units_q + DELAY_W'(1);
                    if (last_unit) begin
                        state_d = FIN;
                    end
                end
                if (bus.abort && !expiring) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            target_q  <= '0;
            units_q   <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            units_q   <= units_d;
            aborted_q <= aborted_d;
        end
    end

    assign bus.req_ready     = (state_q == IDLE);
    assign bus.busy          = (state_q == RUN);
    assign bus.done          = (state_q == FIN);
    assign bus.aborted       = aborted_q;
    assign bus.units_elapsed = units_q;
    assign bus.prec_count    = prec_cnt;
    assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_ts_delay_server.sv
module tb_ts_delay_server;
    import ts_delay_pkg::*;

    localparam int R  = 4;
    localparam int DW = 16;

    logic clock = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] exp_q[$];

    ts_delay_server_if #(.UNIT_RATIO(R), .DELAY_W(DW)) bus ();

    ts_delay_server #(.UNIT_RATIO(R), .DELAY_W(DW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- clock / reset / cycle counter ----------------
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [DW-1:0] d, output int hs);
        step();
        bus.req_valid = 1'b1;
        bus.req_delay = d;
        sample();
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL issue_ready got=%0b exp=1", bus.req_ready);
        end
        hs = cyc;
        step();
        bus.req_valid = 1'b0;
        bus.req_delay = $urandom_range(0, 65535);
    endtask

    // Waits for done, counting busy cycles; pops the expected done cycle.
    task automatic wait_done(input int budget, output int done_cyc, output int busy_cyc);
        logic [31:0] e;
        done_cyc = -1;
        busy_cyc = 0;
        for (int i = 0; i < budget; i++) begin
            sample();
            if (bus.done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            if (bus.busy === 1'b1) busy_cyc++;
        end
        checks++;
        if (done_cyc < 0) begin
            failures++;
            $display("FAIL done_timeout got=none exp=done within %0d cycles", budget);
        end else if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL done_unexpected got=cycle %0d exp=no done", done_cyc);
        end else begin
            e = exp_q.pop_front();
            if (32'(done_cyc) !== e) begin
                failures++;
                $display("FAIL done_cycle got=%0d exp=%0d", done_cyc, e);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) step();
        sample();
        checks++;
        if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0b exp=1", bus.req_ready); end
        checks++;
        if ({bus.busy, bus.done, bus.aborted} !== 3'b000) begin
            failures++; $display("FAIL rst_flags got=%b exp=000", {bus.busy, bus.done, bus.aborted});
        end
        checks++;
        if (bus.units_elapsed !== 16'd0 || bus.prec_count !== 2'd0) begin
            failures++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", bus.units_elapsed, bus.prec_count);
        end
        checks++;
        if (bus.dbg_state !== IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", bus.dbg_state, IDLE); end
        step();
        reset_n = 1'b1;
        sample();
        checks++;
        if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%0b exp=1", bus.req_ready); end
    endtask

    task automatic test_basic();
        int hs, dc, bc;
        bus.tick_en = 1'b1;
        issue(16'd10, hs);
        exp_q.push_back(32'(hs + 10 * R + 1));
        wait_done(200, dc, bc);
        checks++;
        if (bc != 10 * R) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", bc, 10 * R); end
        checks++;
        if (bus.units_elapsed !== 16'd10) begin failures++; $display("FAIL basic_units got=%0d exp=10", bus.units_elapsed); end
        checks++;
        if (bus.prec_count !== 2'd0) begin failures++; $display("FAIL basic_prec got=%0d exp=0", bus.prec_count); end
        step();
        sample();
        checks++;
        if (bus.done !== 1'b0 || bus.req_ready !== 1'b1) begin
            failures++; $display("FAIL basic_after got=done%0b/ready%0b exp=done0/ready1", bus.done, bus.req_ready);
        end
    endtask

    task automatic test_zero();
        int hs, dc, bc;
        issue(16'd0, hs);
        exp_q.push_back(32'(hs + 1));
        wait_done(4, dc, bc);
        checks++;
        if (bus.req_ready !== 1'b0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL zero_fin got=ready%0b/busy%0b exp=ready0/busy0", bus.req_ready, bus.busy);
        end
        checks++;
        if (bc != 0) begin failures++; $display("FAIL zero_busy_cycles got=%0d exp=0", bc); end
        step();
        sample();
        checks++;
        if (bus.req_ready !== 1'b1 || bus.done !== 1'b0) begin
            failures++; $display("FAIL zero_after got=ready%0b/done%0b exp=ready1/done0", bus.req_ready, bus.done);
        end
    endtask

    task automatic test_gapped();
        int hs;
        int dc = -1;
        int m_prec = 0;
        int m_units = 0;
        logic [31:0] e;
        bus.tick_en = 1'b0;
        issue(16'd2, hs);
        for (int i = 0; i < 100; i++) begin
            sample();
            checks++;
            if (bus.prec_count !== 2'(m_prec) || bus.units_elapsed !== 16'(m_units)) begin
                failures++;
                $display("FAIL gap_counters got=%0d/%0d exp=%0d/%0d", bus.units_elapsed, bus.prec_count, m_units, m_prec);
            end
            if (bus.done === 1'b1) begin
                dc = cyc;
                break;
            end
            if (bus.busy === 1'b1 && bus.tick_en === 1'b1) begin
                if (m_prec == R - 1) begin
                    m_prec = 0;
                    m_units++;
                    if (m_units == 2) exp_q.push_back(32'(cyc + 1));
                end else begin
                    m_prec++;
                end
            end
            step();
            bus.tick_en = ~bus.tick_en;
        end
        checks++;
        if (dc < 0) begin
            failures++; $display("FAIL gap_timeout got=none exp=done");
        end else begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            if (32'(dc) !== e) begin failures++; $display("FAIL gap_done_cycle got=%0d exp=%0d", dc, e); end
        end
        checks++;
        if (dc - hs != 17) begin failures++; $display("FAIL gap_latency got=%0d exp=17", dc - hs); end
        bus.tick_en = 1'b1;
    endtask

    task automatic test_abort();
        int hs;
        int found = 0;
        int n_done = 0;
        int n_ab = 0;
        bus.tick_en = 1'b1;
        issue(16'd5, hs);
        for (int i = 0; i < 100; i++) begin
            if (bus.units_elapsed == 16'd2 && bus.prec_count == 2'd1) begin
                found = 1;
                break;
            end
            step();
        end
        checks++;
        if (found == 0) begin failures++; $display("FAIL abort_reach got=not reached exp=2/1"); end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        sample();
        checks++;
        if (bus.aborted !== 1'b1 || bus.done !== 1'b0) begin
            failures++; $display("FAIL abort_pulse got=aborted%0b/done%0b exp=aborted1/done0", bus.aborted, bus.done);
        end
        checks++;
        if (bus.dbg_state !== IDLE || bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL abort_state got=%0d exp=%0d", bus.dbg_state, IDLE);
        end
        checks++;
        if (bus.units_elapsed !== 16'd2 || bus.prec_count !== 2'd1) begin
            failures++; $display("FAIL abort_counters got=%0d/%0d exp=2/1", bus.units_elapsed, bus.prec_count);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            sample();
            if (bus.done === 1'b1) n_done++;
            if (bus.aborted === 1'b1) n_ab++;
        end
        checks++;
        if (n_done != 0 || n_ab != 0) begin
            failures++; $display("FAIL abort_after got=done%0d/aborted%0d exp=0/0", n_done, n_ab);
        end
        checks++;
        if (bus.units_elapsed !== 16'd2 || bus.prec_count !== 2'd1) begin
            failures++; $display("FAIL abort_hold got=%0d/%0d exp=2/1", bus.units_elapsed, bus.prec_count);
        end
    endtask

    task automatic test_abort_final();
        int hs, dc, bc;
        int found = 0;
        bus.tick_en = 1'b1;
        issue(16'd1, hs);
        exp_q.push_back(32'(hs + R + 1));
        for (int i = 0; i < 20; i++) begin
            if (bus.prec_count == 2'(R - 1)) begin
                found = 1;
                break;
            end
            step();
        end
        checks++;
        if (found == 0) begin failures++; $display("FAIL absfin_reach got=not reached exp=prec %0d", R - 1); end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        wait_done(3, dc, bc);
        checks++;
        if (bus.aborted !== 1'b0) begin failures++; $display("FAIL absfin_aborted got=%0b exp=0", bus.aborted); end
        step();
        sample();
        checks++;
        if (bus.aborted !== 1'b0 || bus.done !== 1'b0) begin
            failures++; $display("FAIL absfin_after got=aborted%0b/done%0b exp=0/0", bus.aborted, bus.done);
        end
    endtask

    task automatic test_reset_mid_run();
        int hs, dc, bc;
        int found = 0;
        int n_pulse = 0;
        bus.tick_en = 1'b1;
        issue(16'd5, hs);
        for (int i = 0; i < 100; i++) begin
            if (bus.units_elapsed == 16'd3) begin
                found = 1;
                break;
            end
            step();
        end
        checks++;
        if (found == 0) begin failures++; $display("FAIL rmid_reach got=not reached exp=units 3"); end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        sample();
        checks++;
        if ({bus.busy, bus.done, bus.aborted} !== 3'b000 || bus.req_ready !== 1'b1) begin
            failures++; $display("FAIL rmid_flags got=%b ready%0b exp=000 ready1", {bus.busy, bus.done, bus.aborted}, bus.req_ready);
        end
        checks++;
        if (bus.units_elapsed !== 16'd0 || bus.prec_count !== 2'd0) begin
            failures++; $display("FAIL rmid_counters got=%0d/%0d exp=0/0", bus.units_elapsed, bus.prec_count);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            sample();
            if (bus.done === 1'b1 || bus.aborted === 1'b1) n_pulse++;
        end
        checks++;
        if (n_pulse != 0) begin failures++; $display("FAIL rmid_pulses got=%0d exp=0", n_pulse); end
        issue(16'd1, hs);
        exp_q.push_back(32'(hs + R + 1));
        wait_done(20, dc, bc);
        checks++;
        if (bc != R) begin failures++; $display("FAIL rmid_busy_cycles got=%0d exp=%0d", bc, R); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset_n       = 1'b0;
        bus.tick_en   = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_delay = '0;
        bus.abort     = 1'b0;

        test_reset();
        test_basic();
        test_zero();
        test_gapped();
        test_abort();
        test_abort_final();
        test_reset_mid_run();

        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=time %0t exp=finish earlier", $time);
        $fatal(1, "timeout");
    end

endmodule
